cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//  Parametrised multi-cycle control sequencer for the 16-bit CPU core; next generation of the fixed RESET/FETCH/DECODE/EXECUTE loop.
//  Owns the PC register and all per-phase strobes: instruction-memory wait-states, multi-cycle execute stall, halt and vectored interrupt entry.
//  Adds a wait-state timeout that produces a bus error.
//  Sits between instrMem/dataMem, Control_Unit and ALU in the cpu top level.
// PARAMETERS
//  PC_W      10     PC / branch-target width
//  RESET_PC  0      PC value loaded on reset
//  IRQ_VEC   10'h3F0 PC loaded on interrupt entry
//  TMO_W     4      width of the wait-state timeout counter; timeout at 2**TMO_W-1 wait cycles
// PORTS
//  clk        in   1     system clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  imem_ready in   1     instruction memory has data valid this cycle
//  hlt        in   1     CU decode: halt instruction
//  bra        in   1     CU decode: branch taken
//  br_target  in   PC_W  branch destination (BADR)
//  exec_busy  in   1     execute unit needs another cycle
//  irq        in   1     level interrupt request
//  irq_en     in   1     interrupts globally enabled
//  pc         out  PC_W  current program counter
//  epc        out  PC_W  PC saved on interrupt entry
//  fetch_req  out  1     request to instruction memory
//  ir_load    out  1     load IR this cycle
//  cu_en      out  1     control-unit decode enable
//  exec_en    out  1     ALU/mem/stack operations enabled
//  pc_en      out  1     instruction retires this cycle
//  irq_ack    out  1     one-cycle interrupt acknowledge
//  halted     out  1     core halted
//  bus_err    out  1     sticky fetch timeout flag
//  st         out  3     current state, for debug
// BEHAVIOUR
//  Reset: st=RESET, pc=RESET_PC, epc=0, bus_err=0, timer=0; every strobe is 0 while rst=1.
//  States: RESET=0, FETCH=1, DECODE=2, EXECUTE=3, IRQ=4, HALT=5. State, pc, epc, bus_err and the timer are registered.
//  RESET: no strobes; moves to FETCH on the first clk after rst deasserts.
//  FETCH: fetch_req=1.
//   - imem_ready=1: ir_load=1 (combinational), timer cleared, go to DECODE.
//   - imem_ready=0 with timer < max: timer increments.
//   - imem_ready=0 with timer == 2**TMO_W-1: bus_err<=1, go to HALT.
//  DECODE: cu_en=1. Priority hlt > bra.
//   - hlt: go to HALT.
//   - bra: pc<=br_target, go to FETCH; the branch instruction takes no EXECUTE.
//   - otherwise: go to EXECUTE.
//  EXECUTE: exec_en=1.
//   - exec_busy=1: stay; pc_en=0.
//   - exec_busy=0: pc_en=1 (combinational) and pc<=pc+1. The increment wraps modulo 2**PC_W (all ones -> 0).
//     Then go to IRQ if (irq & irq_en), else to FETCH.
//  IRQ (1 cycle): irq_ack=1, epc<=pc (the already-incremented return address), pc<=IRQ_VEC, go to FETCH.
//  HALT: halted=1.
//   - Wakes when irq & irq_en: goes to IRQ, leaves bus_err unchanged.
//   - Otherwise leaves only through rst.
//  Interrupts are sampled only at the end of EXECUTE or in HALT.
//   - An irq seen during FETCH/DECODE is deferred.
//   - A branch in DECODE is taken first; the irq is serviced after the next retiring EXECUTE.
//  bus_err is cleared only by rst.
//  Undefined st codes (6, 7) go to RESET on the next clk.
//  Reset mid-operation: every register returns to its reset value immediately (asynchronous); any in-flight fetch or execute is abandoned.
//  Latency: non-branch instruction = 3 cycles + wait cycles + busy cycles; taken branch = 2 cycles.
// STRUCTURE
//  Shared package cpu_seq_pkg: state-encoding localparams (ST_RESET..ST_HALT, 3-bit) and ST_W=3.
//  Sub-module seq_wait_timer (TMO_W):
//   - inputs clk, rst, clr, inc.
//   - output expired = (count == 2**TMO_W-1).
//   - counter saturates at the maximum.
//  The top level holds the state register, the PC/EPC registers and the strobe decode.
// TESTING
//  1. rst pulse, imem_ready=1, no hlt/bra/busy
//     -> st sequence 0,1,2,3,1,...; pc=0,1,2 at successive FETCHes; one pc_en pulse per 3 cycles.
//  2. imem_ready low for 3 cycles in FETCH
//     -> fetch_req held for 4 cycles; ir_load only on the ready cycle; bus_err=0.
//  3. imem_ready stuck 0 with TMO_W=4
//     -> after 15 wait cycles bus_err=1, st=HALT, halted=1.
//  4. DECODE with bra=1 and br_target=10'h155
//     -> next state FETCH with pc=0x155, no pc_en.
//  5. DECODE with hlt=bra=1
//     -> HALT, pc unchanged.
//  6. irq=1, irq_en=1 asserted in DECODE at pc=0x3FF
//     -> EXECUTE retires with pc wrapping to 0; IRQ: irq_ack=1, epc=0, pc=0x3F0.
//  7. rst asserted mid-EXECUTE with exec_busy=1
//     -> outputs drop to reset values before the next clk edge.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: state encodings shared by the cpu sequencer and its bench
package cpu_seq_pkg;
    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_RESET   = 3'd0;
    localparam logic [ST_W-1:0] ST_FETCH   = 3'd1;
    localparam logic [ST_W-1:0] ST_DECODE  = 3'd2;
    localparam logic [ST_W-1:0] ST_EXECUTE = 3'd3;
    localparam logic [ST_W-1:0] ST_IRQ     = 3'd4;
    localparam logic [ST_W-1:0] ST_HALT    = 3'd5;
    typedef enum logic [ST_W-1:0] {
        S_RESET   = ST_RESET,
        S_FETCH   = ST_FETCH,
        S_DECODE  = ST_DECODE,
        S_EXECUTE = ST_EXECUTE,
        S_IRQ     = ST_IRQ,
        S_HALT    = ST_HALT
    } state_t;
endpackage

// File: rtl/seq_wait_timer.sv
// seq_wait_timer: saturating instruction-fetch wait-state counter
module seq_wait_timer #(
    parameter int TMO_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    logic [TMO_W-1:0] count;
    assign expired = &count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !expired)
            count <= count + TMO_W'(1);
    end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute control with wait-state timeout and vectored irq
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] IRQ_VEC  = PC_W'('h3F0),
    parameter int              TMO_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_ready,
    input  logic            hlt,
    input  logic            bra,
    input  logic [PC_W-1:0] br_target,
    input  logic            exec_busy,
    input  logic            irq,
    input  logic            irq_en,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] epc,
    output logic            fetch_req,
    output logic            ir_load,
    output logic            cu_en,
    output logic            exec_en,
    output logic            pc_en,
    output logic            irq_ack,
    output logic            halted,
    output logic            bus_err,
    output logic [ST_W-1:0] st
);
    state_t          state, nxt;
    logic [PC_W-1:0] pc_nxt, epc_nxt;
    logic            err_nxt, expired, irq_take;

    // timer only runs while stalled in FETCH so every fetch gets a fresh budget
    seq_wait_timer #(.TMO_W(TMO_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != S_FETCH || imem_ready),
        .inc     (state == S_FETCH && !imem_ready),
        .expired (expired)
    );

    assign irq_take  = irq & irq_en;
    assign st        = state;
    assign fetch_req = state == S_FETCH;
    assign ir_load   = state == S_FETCH && imem_ready;
    assign cu_en     = state == S_DECODE;
    assign exec_en   = state == S_EXECUTE;
    assign pc_en     = state == S_EXECUTE && !exec_busy;
    assign irq_ack   = state == S_IRQ;
    assign halted    = state == S_HALT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_RESET;
            pc      <= RESET_PC;
            epc     <= '0;
            bus_err <= 1'b0;
        end else begin
            state   <= nxt;
            pc      <= pc_nxt;
            epc     <= epc_nxt;
            bus_err <= err_nxt;
        end
    end

    always_comb begin
        nxt     = state;
        pc_nxt  = pc;
        epc_nxt = epc;
        err_nxt = bus_err;
        case (state)
            S_RESET: nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ready)
                    nxt = S_DECODE;
                else if (expired) begin
                    err_nxt = 1'b1;
                    nxt     = S_HALT;
                end
            end
            S_DECODE: begin
                if (hlt)
                    nxt = S_HALT;
                else if (bra) begin
                    pc_nxt = br_target;
                    nxt    = S_FETCH;
                end else
                    nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (!exec_busy) begin
                    pc_nxt = pc + PC_W'(1);
                    nxt    = irq_take ? S_IRQ : S_FETCH;
                end
            end
            S_IRQ: begin
                epc_nxt = pc;
                pc_nxt  = IRQ_VEC;
                nxt     = S_FETCH;
            end
            S_HALT: nxt = irq_take ? S_IRQ : S_HALT;
            default: nxt = S_RESET;
        endcase
    end
endmodule
